// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Accepts one word per handshake and holds packed BCD digits plus a saturation flag.
module bin2bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  out_valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_conv: WIDTH must be in 4..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin2bcd_conv: DIGITS must be in 1..10");
    end

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [BW-1:0]    scratch_q,   scratch_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             sticky_q,    sticky_d;
    logic [BW-1:0]    bcd_q,       bcd_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [BW-1:0]    adj;

    // Add-3 correction is strictly per digit; no carry crosses a digit boundary.
    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                // The bit pushed out of the top digit means the value no longer fits.
                scratch_d = {adj[BW-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                sticky_d  = sticky_q | adj[BW-1];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d       = sticky_q ? ALL_NINES : scratch_q;
                ovf_d       = sticky_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Self-checking bench for bin2bcd_conv at default parameters (16-bit in, 4 digits out).
// Directed vector table, hand-written handshake/reset sequences and a random sweep.
module tb_bin2bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd;
    logic        ovf;
    logic        out_valid;

    bin2bcd_conv #(.WIDTH(16), .DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    int  n_checks = 0;
    int  n_errors = 0;
    int  accepts  = 0;
    int  pulses   = 0;
    int  stable_viol = 0;
    logic [15:0] last_bcd;
    time t_accept;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_model(input int v, output logic [15:0] b, output logic o);
        int p;
        p = v;
        b = '0;
        o = 1'b0;
        if (v > 9999) begin
            b = 16'h9999;
            o = 1'b1;
        end else begin
            for (int d = 0; d < 4; d++) begin
                b[4*d +: 4] = 4'(p % 10);
                p = p / 10;
            end
        end
    endfunction

    // Counts result pulses and flags any bcd movement outside a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            last_bcd = '0;
        end else if (out_valid) begin
            pulses++;
            last_bcd = bcd;
        end else if (bcd !== last_bcd) begin
            stable_viol++;
        end
    end

    task automatic convert(input logic [15:0] b, output logic [15:0] got_bcd,
                           output logic got_ovf, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        bin      = b;
        in_valid = 1'b1;
        @(posedge clk);
        t_accept = $time;
        #1;
        in_valid = 1'b0;
        bin      = ~b;
        accepts++;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
        got_bcd = bcd;
        got_ovf = ovf;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gb;
        logic        go;
        logic [15:0] eb;
        logic        eo;
        int          lat;
        int          k;
        int          v;
        time         t1;

        vecs[0]  = '{16'd0,     16'h0000, 1'b0};
        vecs[1]  = '{16'd1234,  16'h1234, 1'b0};
        vecs[2]  = '{16'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{16'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{16'hFFFF,  16'h9999, 1'b1};
        vecs[5]  = '{16'd7,     16'h0007, 1'b0};
        vecs[6]  = '{16'h0042,  16'h0066, 1'b0};
        vecs[7]  = '{16'd9,     16'h0009, 1'b0};
        vecs[8]  = '{16'd10,    16'h0010, 1'b0};
        vecs[9]  = '{16'd999,   16'h0999, 1'b0};
        vecs[10] = '{16'd5000,  16'h5000, 1'b0};
        vecs[11] = '{16'd10001, 16'h9999, 1'b1};

        // Reset with in_valid asserted: nothing may be accepted.
        rst      = 1'b0;
        in_valid = 1'b1;
        bin      = 16'h1234;
        #2;
        check("rst_bcd",       32'(bcd),       32'h0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready),  32'd1);
        check("post_rst_ov",    32'(out_valid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, gb, go, lat);
            check($sformatf("vec%0d_bcd", i), 32'(gb),  32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(go),  32'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd17);
        end

        // Back-to-back accepts are WIDTH+2 cycles apart; out_valid is a single cycle.
        convert(16'd1234, gb, go, lat);
        t1 = t_accept;
        check("b2b_first_bcd", 32'(gb), 32'h1234);
        convert(16'd9999, gb, go, lat);
        check("b2b_spacing", 32'((t_accept - t1) / 10), 32'd18);
        check("b2b_second_bcd", 32'(gb), 32'h9999);
        check("b2b_second_ovf", 32'(go), 32'd0);
        @(posedge clk); #1;
        check("pulse_width", 32'(out_valid), 32'd0);

        // in_valid held with a changing bin during conversion.
        bin      = 16'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        accepts++;
        k = 0;
        while (!out_valid && k < 40) begin
            check("busy_ready", 32'(in_ready), 32'd0);
            check("hold_bcd",   32'(bcd),      32'h9999);
            bin = 16'($urandom);
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check("held_done",    32'(out_valid), 32'd1);
        check("held_latency", 32'(k),         32'd17);
        check("held_bcd",     32'(bcd),       32'h0005);
        check("held_ovf",     32'(ovf),       32'd0);
        check("held_ready",   32'(in_ready),  32'd1);

        // Asynchronous reset mid-conversion aborts without a result pulse.
        bin      = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_bcd",       32'(bcd),       32'h0);
        check("abort_ovf",       32'(ovf),       32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_ready",     32'(in_ready),  32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_no_pulse", 32'(out_valid), 32'd0);
        convert(16'h0042, gb, go, lat);
        check("after_abort_bcd", 32'(gb),  32'h0066);
        check("after_abort_ovf", 32'(go),  32'd0);
        check("after_abort_lat", 32'(lat), 32'd17);

        for (int i = 0; i < 150; i++) begin
            v = int'($urandom_range(0, 65535));
            convert(16'(v), gb, go, lat);
            ref_model(v, eb, eo);
            check($sformatf("rand_bcd(%0d)", v), 32'(gb),  32'(eb));
            check($sformatf("rand_ovf(%0d)", v), 32'(go),  32'(eo));
            check($sformatf("rand_lat(%0d)", v), 32'(lat), 32'd17);
        end

        repeat (3) @(posedge clk);
        #1;
        check("pulse_count", 32'(pulses),      32'(accepts));
        check("bcd_stable",  32'(stable_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_conv.md
# bin2bcd_conv

Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) between the core's `data_seg[15:0]` output and the seven-segment scanner's digit inputs, clocked on `sysclk`. It accepts one binary word per handshake and produces packed BCD digits plus a saturation flag. The digit bus holds its value between conversions, so the scanner always shows a stable number.

## Interface
- `WIDTH`, default 16: binary input width; legal range 4..32.
- `DIGITS`, default 4: BCD digits produced; legal range 1..10.
- `clk` input 1: system clock (`sysclk` in top).
- `rst` input 1: asynchronous, active-low reset; one clock, no other reset.
- `bin` input WIDTH: unsigned binary value, sampled on an accepted handshake.
- `in_valid` input 1: `bin` is valid.
- `in_ready` output 1: converter idle and able to accept.
- `bcd` output 4*DIGITS: packed BCD, digit 0 (ones) in bits [3:0]; holds the last result.
- `ovf` output 1: last result saturated (`bin` ≥ 10^DIGITS); holds with `bcd`.
- `out_valid` output 1: one-cycle pulse when `bcd`/`ovf` update.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`=1 at a rising edge, capture `bin` into the shift register, clear the BCD scratch (4*DIGITS bits), clear the sticky overflow, set bit counter=0, and go to CONV.
  - CONV: each edge, first add 3 to every scratch digit ≥5, then shift {scratch, shift-reg} left by 1, with the binary MSB entering scratch bit 0. Increment the counter. After the WIDTH-th shift, go to DONE.
  - DONE: register the result onto `bcd`/`ovf`, assert `out_valid` for one cycle, and return to IDLE.
- Overflow: on any shift, the bit leaving scratch MSB (after adjust) being 1 sets the sticky overflow. If it is set in DONE, `bcd` = all digits 9 and `ovf`=1. Otherwise `bcd` = scratch and `ovf`=0.
- `in_ready` is combinational: high exactly when the state is IDLE. `in_valid` in CONV/DONE is ignored, with no queuing. Upstream must hold `bin` until accepted.
- Counter width is $clog2(WIDTH+1). Arithmetic is per-digit 4-bit; adjust carries never cross digits.
- Illegal parameters are a compile-time error; there is no runtime check.

## Timing
- Reset values (while `rst`=0): state IDLE, `bcd`=0, `ovf`=0, `out_valid`=0, counter=0, scratch=0. `in_ready` reads 1, but no accept occurs while `rst`=0.
- Reset asserted mid-CONV/DONE aborts immediately. The previous `bcd` is lost (0), and there is no `out_valid` for the aborted word.
- Accept at edge E0. Shifts occur at E1..E_WIDTH. DONE is entered after E_WIDTH. `bcd`/`ovf`/`out_valid` update at E_WIDTH+1 and remain visible during the following cycle.
- Latency from accept edge to result edge is WIDTH+1 edges (17 at defaults).
- `in_ready` returns high at the same edge `out_valid` rises. A new word presented then is accepted at the next edge, giving a throughput of one conversion per WIDTH+2 cycles.
- `bcd`/`ovf` change only at DONE edges or on reset, never mid-conversion.

## Test plan
- Reset, then `bin`=0x0000 with `in_valid` pulse → `out_valid` 17 edges after accept, `bcd`=0x0000, `ovf`=0.
- `bin`=0x04D2 (1234) → `bcd`=0x1234, `ovf`=0. Then `bin`=0x270F (9999) back-to-back → `bcd`=0x9999, `ovf`=0. Consecutive accepts are exactly 18 cycles apart.
- `bin`=0x2710 (10000) → `bcd`=0x9999, `ovf`=1. `bin`=0xFFFF → `bcd`=0x9999, `ovf`=1. A following `bin`=0x0007 → `bcd`=0x0007, `ovf`=0 (flag not sticky across words).
- `in_valid` held high with a changing `bin` during CONV → `in_ready`=0 throughout; only the accepted word converts; `bcd` is unchanged until DONE.
- `rst` dropped asynchronously (mid-cycle) at shift 8 of a 1234 conversion → `bcd`=0, `ovf`=0, `out_valid`=0 immediately, state IDLE. After release, 0x0042 → `bcd`=0x0066.
- Random sweep of 0..65535 against a reference model (`bcd` = decimal digits, or 9999/`ovf`=1 if >9999). Checks include one `out_valid` per accept and `bcd` stable between pulses.
